elbeth_fetch_unit: RTL and testbench

//  Instruction-fetch stage of the ELBETH pipeline. Upstream of the control unit and decode.

---
 rtl/elbeth_fetch_unit_pkg.sv | 28 ++
 rtl/elbeth_fetch_unit_if.sv | 24 ++
 rtl/elbeth_fetch_unit_pc_gen.sv | 40 ++++
 rtl/elbeth_fetch_unit.sv | 113 +++++++++++
 tb/tb_elbeth_fetch_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/elbeth_fetch_unit_pkg.sv
// rtl/elbeth_fetch_unit_pkg.sv - shared constants and types for the ELBETH fetch stage
package elbeth_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0200;

    typedef enum logic [1:0] {
        PC_SEL_PC4    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_EXCEPT = 2'd2,
        PC_SEL_EPC    = 2'd3
    } pc_sel_t;

    localparam logic EXC_IF_MISALIGNED = 1'b0;
    localparam logic EXC_IF_FAULT      = 1'b1;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic        except;
        logic        cause;
    } ifid_t;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/elbeth_fetch_unit_if.sv
// rtl/elbeth_fetch_unit_if.sv - instruction-memory request/response handshake
interface elbeth_fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_fault;

    modport master (
        output imem_addr,
        output imem_en,
        input  imem_ready,
        input  imem_rdata,
        input  imem_fault
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        output imem_ready,
        output imem_rdata,
        output imem_fault
    );
endinterface

// File: rtl/elbeth_fetch_unit_pc_gen.sv
// rtl/elbeth_fetch_unit_pc_gen.sv - next-PC select and PC register
module elbeth_fetch_unit_pc_gen
    import elbeth_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_select,
    input  logic [31:0] branch_target,
    input  logic [31:0] exception_pc,
    input  logic [31:0] epc,
    input  logic        advance,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc + 32'd4;
        case (pc_select)
            PC_SEL_PC4:    next_pc = pc + 32'd4;
            PC_SEL_BRANCH: next_pc = branch_target;
            PC_SEL_EXCEPT: next_pc = exception_pc;
            PC_SEL_EPC:    next_pc = epc;
            default:       next_pc = pc + 32'd4;
        endcase
    end

    // A flush redirects even when the PC is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else if (flush || (advance && !stall)) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/elbeth_fetch_unit.sv
// rtl/elbeth_fetch_unit.sv - ELBETH instruction-fetch stage with IF/ID register
module elbeth_fetch_unit
    import elbeth_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] NOP_WORD     = NOP_INSTR
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  if_pc_select,
    input  logic                        if_pc_stall,
    input  logic                        if_stall,
    input  logic                        if_flush,
    input  logic [31:0]                 branch_target,
    input  logic [31:0]                 exception_pc,
    input  logic [31:0]                 epc,
    elbeth_fetch_unit_if.master         imem,
    output logic [31:0]                 id_instruction,
    output logic [31:0]                 id_pc,
    output logic                        id_except_from_if,
    output logic                        id_except_cause
);

    typedef enum logic [1:0] {BOOT, FETCH, HELD, TRAP} state_t;

    state_t      state;
    ifid_t       ifid;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        trap_cause;
    logic        aligned;
    logic        accept;
    logic        drain;

    always_comb begin
        aligned = pc_aligned(pc);
        accept  = (state == FETCH) && !if_flush && aligned && imem.imem_ready
                  && !imem.imem_fault && !if_stall;
        drain   = (state == HELD) && !if_flush && !if_stall;
    end

    elbeth_fetch_unit_pc_gen #(.RESET_VECTOR(RESET_VECTOR)) u_pc_gen (
        .clk           (clk),
        .rst           (rst),
        .pc_select     (if_pc_select),
        .branch_target (branch_target),
        .exception_pc  (exception_pc),
        .epc           (epc),
        .advance       (accept || drain),
        .stall         (if_pc_stall),
        .flush         (if_flush),
        .pc            (pc),
        .next_pc       (next_pc)
    );

    assign imem.imem_en   = (state == FETCH) && aligned && !rst;
    assign imem.imem_addr = pc;

    assign id_instruction    = ifid.instruction;
    assign id_pc             = ifid.pc;
    assign id_except_from_if = ifid.except;
    assign id_except_cause   = ifid.cause;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            ifid       <= '{NOP_WORD, 32'd0, 1'b0, 1'b0};
            buf_instr  <= NOP_WORD;
            buf_pc     <= 32'd0;
            trap_cause <= EXC_IF_MISALIGNED;
        end else if (if_flush) begin
            // Aborts any outstanding request; its response is never consumed.
            state <= FETCH;
            ifid  <= '{NOP_WORD, pc, 1'b0, 1'b0};
        end else begin
            case (state)
                BOOT: state <= FETCH;
                FETCH: begin
                    if (!aligned) begin
                        state      <= TRAP;
                        trap_cause <= EXC_IF_MISALIGNED;
                        if (!if_stall) ifid <= '{NOP_WORD, pc, 1'b0, 1'b0};
                    end else if (imem.imem_ready && imem.imem_fault) begin
                        state      <= TRAP;
                        trap_cause <= EXC_IF_FAULT;
                        if (!if_stall) ifid <= '{NOP_WORD, pc, 1'b0, 1'b0};
                    end else if (imem.imem_ready && !if_stall) begin
                        ifid <= '{imem.imem_rdata, pc, 1'b0, 1'b0};
                    end else if (imem.imem_ready) begin
                        buf_instr <= imem.imem_rdata;
                        buf_pc    <= pc;
                        state     <= HELD;
                    end else if (!if_stall) begin
                        ifid <= '{NOP_WORD, pc, 1'b0, 1'b0};
                    end
                end
                HELD: begin
                    if (!if_stall) begin
                        ifid  <= '{buf_instr, buf_pc, 1'b0, 1'b0};
                        state <= FETCH;
                    end
                end
                TRAP: begin
                    if (!if_stall) ifid <= '{NOP_WORD, pc, 1'b1, trap_cause};
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_elbeth_fetch_unit.sv
// tb/tb_elbeth_fetch_unit.sv - self-checking bench for elbeth_fetch_unit
module tb_elbeth_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  if_pc_select;
    logic        if_pc_stall;
    logic        if_stall;
    logic        if_flush;
    logic [31:0] branch_target;
    logic [31:0] exception_pc;
    logic [31:0] epc;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        id_except_from_if;
    logic        id_except_cause;

    elbeth_fetch_unit_if imem ();

    elbeth_fetch_unit dut (
        .clk               (clk),
        .rst               (rst),
        .if_pc_select      (if_pc_select),
        .if_pc_stall       (if_pc_stall),
        .if_stall          (if_stall),
        .if_flush          (if_flush),
        .branch_target     (branch_target),
        .exception_pc      (exception_pc),
        .epc               (epc),
        .imem              (imem.master),
        .id_instruction    (id_instruction),
        .id_pc             (id_pc),
        .id_except_from_if (id_except_from_if),
        .id_except_cause   (id_except_cause)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    int exp_hs   = 0;

    always @(posedge clk) begin
        if (!rst && imem.imem_en && imem.imem_ready) hs_count <= hs_count + 1;
    end

    typedef struct {
        logic        ready;
        logic        stall;
        logic [31:0] rdata;
        logic        hs;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        chk_pc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_t;

    vec_t vecs[9];
    sb_t  sb[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_trap(input logic exp_cause, input logic [31:0] exp_pc);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            cyc();
            check("trap_no_request", {31'd0, imem.imem_en}, 32'd0);
            if (id_except_from_if) seen = 1'b1;
        end
        check("trap_except", {31'd0, id_except_from_if}, 32'd1);
        check("trap_cause", {31'd0, id_except_cause}, {31'd0, exp_cause});
        check("trap_pc", id_pc, exp_pc);
        check("trap_instr", id_instruction, NOP);
    endtask

    initial begin
        logic [31:0] model_pc;
        sb_t e;

        vecs[0] = '{1'b1, 1'b0, 32'h0050_0093, 1'b1, 1'b1, 32'h204, 32'h0050_0093, 32'h200, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h204, NOP,           32'h0,   1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h204, NOP,           32'h0,   1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h204, NOP,           32'h0,   1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h00A0_0113, 1'b1, 1'b1, 32'h208, 32'h00A0_0113, 32'h204, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h0140_0193, 1'b1, 1'b0, 32'h208, 32'h00A0_0113, 32'h204, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h208, 32'h00A0_0113, 32'h204, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h20C, 32'h0140_0193, 32'h208, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 32'h0020_8233, 1'b1, 1'b1, 32'h210, 32'h0020_8233, 32'h20C, 1'b1};

        rst = 1'b1;
        if_pc_select = 2'd0;
        if_pc_stall = 1'b0;
        if_stall = 1'b0;
        if_flush = 1'b0;
        branch_target = 32'h0;
        exception_pc = 32'h0;
        epc = 32'h0;
        imem.imem_ready = 1'b0;
        imem.imem_rdata = 32'h0;
        imem.imem_fault = 1'b0;

        cyc();
        cyc();
        check("rst_en", {31'd0, imem.imem_en}, 32'd0);
        check("rst_instr", id_instruction, NOP);
        check("rst_pc", id_pc, 32'h0);
        check("rst_except", {31'd0, id_except_from_if}, 32'd0);
        check("rst_addr", imem.imem_addr, 32'h200);

        rst = 1'b0;
        #1;
        check("boot_en", {31'd0, imem.imem_en}, 32'd0);
        cyc();
        check("first_en", {31'd0, imem.imem_en}, 32'd1);
        check("first_addr", imem.imem_addr, 32'h200);

        for (int i = 0; i < 9; i++) begin
            imem.imem_ready = vecs[i].ready;
            imem.imem_rdata = vecs[i].rdata;
            if_stall = vecs[i].stall;
            if (vecs[i].hs) exp_hs++;
            cyc();
            check($sformatf("vec%0d_en", i), {31'd0, imem.imem_en}, {31'd0, vecs[i].exp_en});
            check($sformatf("vec%0d_addr", i), imem.imem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_instr", i), id_instruction, vecs[i].exp_instr);
            check($sformatf("vec%0d_except", i), {31'd0, id_except_from_if}, 32'd0);
            if (vecs[i].chk_pc) check($sformatf("vec%0d_pc", i), id_pc, vecs[i].exp_pc);
        end
        if_stall = 1'b0;

        model_pc = 32'h210;
        for (int i = 0; i < 24; i++) begin
            imem.imem_ready = 1'($urandom_range(0, 1));
            imem.imem_rdata = $urandom;
            if (imem.imem_ready) begin
                sb.push_back('{imem.imem_rdata, model_pc});
                model_pc = model_pc + 32'd4;
                exp_hs++;
            end
            cyc();
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("stream_instr", id_instruction, e.instr);
                check("stream_pc", id_pc, e.pc);
            end else begin
                check("stream_nop", id_instruction, NOP);
            end
            check("stream_addr", imem.imem_addr, model_pc);
        end

        imem.imem_ready = 1'b0;
        if_flush = 1'b1;
        if_pc_select = 2'd1;
        branch_target = 32'h300;
        cyc();
        check("branch_addr", imem.imem_addr, 32'h300);
        check("branch_en", {31'd0, imem.imem_en}, 32'd1);
        check("branch_instr", id_instruction, NOP);

        branch_target = 32'h302;
        cyc();
        if_flush = 1'b0;
        if_pc_select = 2'd0;
        check("misalign_addr", imem.imem_addr, 32'h302);
        check("misalign_en", {31'd0, imem.imem_en}, 32'd0);
        wait_trap(1'b0, 32'h302);

        if_stall = 1'b1;
        cyc();
        check("trap_stall_hold", {31'd0, id_except_from_if}, 32'd1);
        if_stall = 1'b0;

        if_flush = 1'b1;
        if_pc_select = 2'd2;
        exception_pc = 32'h100;
        cyc();
        if_flush = 1'b0;
        if_pc_select = 2'd0;
        check("vector_addr", imem.imem_addr, 32'h100);
        check("vector_en", {31'd0, imem.imem_en}, 32'd1);
        check("vector_except_clr", {31'd0, id_except_from_if}, 32'd0);

        imem.imem_ready = 1'b1;
        imem.imem_fault = 1'b1;
        exp_hs++;
        cyc();
        imem.imem_ready = 1'b0;
        imem.imem_fault = 1'b0;
        wait_trap(1'b1, 32'h100);

        if_flush = 1'b1;
        if_pc_select = 2'd3;
        epc = 32'h204;
        cyc();
        if_flush = 1'b0;
        if_pc_select = 2'd0;
        check("eret_addr", imem.imem_addr, 32'h204);
        check("eret_except_clr", {31'd0, id_except_from_if}, 32'd0);

        if_flush = 1'b1;
        if_pc_select = 2'd1;
        branch_target = 32'hFFFF_FFFC;
        cyc();
        if_flush = 1'b0;
        if_pc_select = 2'd0;
        imem.imem_ready = 1'b1;
        imem.imem_rdata = 32'h1111_1111;
        exp_hs++;
        cyc();
        imem.imem_ready = 1'b0;
        check("wrap_addr", imem.imem_addr, 32'h0);
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);

        imem.imem_ready = 1'b1;
        imem.imem_rdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        #1;
        check("midrst_en", {31'd0, imem.imem_en}, 32'd0);
        cyc();
        imem.imem_ready = 1'b0;
        check("midrst_instr", id_instruction, NOP);
        check("midrst_addr", imem.imem_addr, 32'h200);
        rst = 1'b0;
        #1;
        check("midrst_boot_en", {31'd0, imem.imem_en}, 32'd0);
        cyc();
        check("midrst_fetch_en", {31'd0, imem.imem_en}, 32'd1);

        check("handshakes", hs_count, exp_hs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
